// File: rtl/ts_sync_detector.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ts_sync_detector : MPEG-2 TS packet sync finder (hunt / verify / lock).
// Optional err_cnt output enabled by defining TS_SYNC_ERRCNT_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
module ts_sync_detector #(
  parameter int         PKT_LEN   = 188,
  parameter logic [7:0] SYNC_BYTE = 8'h47,
  parameter int         LOCK_CNT  = 3,
  parameter int         LOSS_CNT  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  output logic        sync_out,
  output logic        locked,
  output logic        lock_lost,
`ifdef TS_SYNC_ERRCNT_EN
  output logic [15:0] err_cnt,
`endif
  output logic [7:0]  byte_pos
);

  localparam logic [1:0] S_HUNT   = 2'd0;
  localparam logic [1:0] S_VERIFY = 2'd1;
  localparam logic [1:0] S_LOCK   = 2'd2;

  localparam logic [7:0] LAST_POS   = 8'(PKT_LEN - 1);
  localparam logic [2:0] LOCK_CNT_C = 3'(LOCK_CNT);
  localparam logic [2:0] LOSS_CNT_C = 3'(LOSS_CNT);

  logic [1:0] state_q, state_d;
  logic [7:0] pos_q, pos_d;
  logic [2:0] good_q, good_d;
  logic [2:0] miss_q, miss_d;
  logic       sync_q, sync_d;
  logic       lost_q, lost_d;
  logic       locked_q, locked_d;

  logic [7:0] pos_adv;
  logic [2:0] good_inc;
  logic [2:0] miss_inc;
  logic       is_sync;
  logic       is_check;

  assign pos_adv  = (pos_q == LAST_POS) ? 8'd0 : pos_q + 8'd1;
  assign good_inc = good_q + 3'd1;
  assign miss_inc = miss_q + 3'd1;
  assign is_sync  = (data_in == SYNC_BYTE);
  assign is_check = (pos_q == 8'd0);

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    good_d  = good_q;
    miss_d  = miss_q;
    sync_d  = 1'b0;
    lost_d  = 1'b0;
    if (data_valid) begin
      case (state_q)
        S_HUNT: begin
          if (is_sync) begin
            pos_d  = 8'd1;
            good_d = 3'd1;
            if (LOCK_CNT_C == 3'd1) begin
              state_d = S_LOCK;
              miss_d  = 3'd0;
              sync_d  = 1'b1;
            end else begin
              state_d = S_VERIFY;
            end
          end else begin
            pos_d = 8'd0;
          end
        end
        S_VERIFY: begin
          pos_d = pos_adv;
          if (is_check) begin
            if (is_sync) begin
              good_d = good_inc;
              if (good_inc == LOCK_CNT_C) begin
                state_d = S_LOCK;
                miss_d  = 3'd0;
                sync_d  = 1'b1;
              end
            end else begin
              // The failing byte is dropped, not retried as a new candidate.
              state_d = S_HUNT;
              pos_d   = 8'd0;
            end
          end
        end
        S_LOCK: begin
          pos_d = pos_adv;
          if (is_check) begin
            if (is_sync) begin
              miss_d = 3'd0;
              sync_d = 1'b1;
            end else begin
              miss_d = miss_inc;
              if (miss_inc == LOSS_CNT_C) begin
                state_d = S_HUNT;
                pos_d   = 8'd0;
                lost_d  = 1'b1;
              end
            end
          end
        end
        default: begin
          state_d = S_HUNT;
          pos_d   = 8'd0;
        end
      endcase
    end
  end

  assign locked_d = (state_d == S_LOCK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_HUNT;
      pos_q    <= 8'd0;
      good_q   <= 3'd0;
      miss_q   <= 3'd0;
      sync_q   <= 1'b0;
      lost_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      good_q   <= good_d;
      miss_q   <= miss_d;
      sync_q   <= sync_d;
      lost_q   <= lost_d;
      locked_q <= locked_d;
    end
  end

  assign sync_out  = sync_q;
  assign locked    = locked_q;
  assign lock_lost = lost_q;
  assign byte_pos  = pos_q;

`ifdef TS_SYNC_ERRCNT_EN
  logic [15:0] err_q;
  logic        err_hit;

  assign err_hit = data_valid && (state_q == S_LOCK) && is_check && !is_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 16'd0;
    end else if (err_hit && (err_q != 16'hFFFF)) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign err_cnt = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ts_sync_detector.sv
`default_nettype none
// tb_ts_sync_detector : randomized + directed bench with a behavioural model.
module tb_ts_sync_detector;

  localparam int PKT_LEN  = 188;
  localparam int LOCK_CNT = 3;
  localparam int LOSS_CNT = 3;
  localparam int M_HUNT   = 0;
  localparam int M_VERIFY = 1;
  localparam int M_LOCK   = 2;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       data_valid;
  logic       sync_out;
  logic       locked;
  logic       lock_lost;
  logic [7:0] byte_pos;
`ifdef TS_SYNC_ERRCNT_EN
  logic [15:0] err_cnt;
`endif

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  ts_sync_detector #(
    .PKT_LEN  (PKT_LEN),
    .SYNC_BYTE(8'h47),
    .LOCK_CNT (LOCK_CNT),
    .LOSS_CNT (LOSS_CNT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .data_valid(data_valid),
    .sync_out  (sync_out),
    .locked    (locked),
    .lock_lost (lock_lost),
`ifdef TS_SYNC_ERRCNT_EN
    .err_cnt   (err_cnt),
`endif
    .byte_pos  (byte_pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int mode;
    int pos;
    int good;
    int miss;
    int err;
    bit sync;
    bit lost;
    bit lck;
  } mdl_t;

  mdl_t m;

  // Spec-level model: one accepted byte moves the model one step.
  function automatic mdl_t model_step(mdl_t cur, bit v, int d);
    mdl_t n;
    bit   hit;
    n      = cur;
    n.sync = 1'b0;
    n.lost = 1'b0;
    hit    = (d == 'h47);
    if (v) begin
      if (cur.mode == M_HUNT) begin
        if (hit) begin
          n.pos  = 1;
          n.good = 1;
          if (LOCK_CNT == 1) begin
            n.mode = M_LOCK; n.miss = 0; n.sync = 1'b1;
          end else begin
            n.mode = M_VERIFY;
          end
        end
      end else begin
        n.pos = (cur.pos + 1) % PKT_LEN;
        if (cur.pos == 0) begin
          if (cur.mode == M_VERIFY) begin
            if (hit) begin
              n.good = cur.good + 1;
              if (n.good == LOCK_CNT) begin
                n.mode = M_LOCK; n.miss = 0; n.sync = 1'b1;
              end
            end else begin
              n.mode = M_HUNT; n.pos = 0;
            end
          end else if (hit) begin
            n.miss = 0; n.sync = 1'b1;
          end else begin
            n.miss = cur.miss + 1;
            if (n.err < 65535) n.err = n.err + 1;
            if (n.miss == LOSS_CNT) begin
              n.mode = M_HUNT; n.pos = 0; n.lost = 1'b1;
            end
          end
        end
      end
    end
    n.lck = (n.mode == M_LOCK);
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m <= '{mode: M_HUNT, pos: 0, good: 0, miss: 0, err: 0, sync: 1'b0, lost: 1'b0, lck: 1'b0};
    end else begin
      m <= model_step(m, data_valid, int'(data_in));
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("sync_out", int'(sync_out), int'(m.sync));
      chk("locked", int'(locked), int'(m.lck));
      chk("lock_lost", int'(lock_lost), int'(m.lost));
      chk("byte_pos", int'(byte_pos), m.pos);
`ifdef TS_SYNC_ERRCNT_EN
      chk("err_cnt", int'(err_cnt), m.err);
`endif
    end
  end

  // Drive at the falling edge; return just after the rising edge that takes it.
  task automatic send_byte(input bit v, input logic [7:0] d);
    @(negedge clk);
    data_valid = v;
    data_in    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int gap);
    if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1))
      send_byte(1'b0, 8'($urandom_range(0, 255)));
  endtask

  task automatic send_payload(input int n, input int gap, input bit allow47);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255));
      if (!allow47 && b == 8'h47) b = 8'h00;
      send_byte(1'b1, b);
      idle(gap);
    end
  endtask

  task automatic send_pkt(input bit good, input int gap, input bit allow47);
    logic [7:0] b;
    b = 8'($urandom_range(0, 254));
    if (b >= 8'h47) b = b + 8'd1;
    send_byte(1'b1, good ? 8'h47 : b);
    idle(gap);
    send_payload(PKT_LEN - 1, gap, allow47);
  endtask

  initial begin
    int r;
    int gap;
    rst        = 1'b1;
    data_valid = 1'b0;
    data_in    = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    run_cmp = 1'b1;
    chk("rst_locked", int'(locked), 0);
    chk("rst_byte_pos", int'(byte_pos), 0);
    chk("rst_sync_out", int'(sync_out), 0);
    @(negedge clk);
    rst = 1'b0;

    // Three clean packets: lock one cycle after the third sync byte.
    send_byte(1'b1, 8'h47);
    chk("first_sync_pos", int'(byte_pos), 1);
    chk("first_sync_unlocked", int'(locked), 0);
    send_payload(PKT_LEN - 1, 0, 1'b0);
    send_pkt(1'b1, 0, 1'b0);
    send_byte(1'b1, 8'h47);
    chk("lock_on_third", int'(locked), 1);
    chk("sync_on_third", int'(sync_out), 1);
    send_payload(PKT_LEN - 1, 0, 1'b0);

    // Two misses then a good sync keep lock.
    send_pkt(1'b0, 0, 1'b0);
    send_pkt(1'b0, 0, 1'b0);
    chk("two_miss_locked", int'(locked), 1);
    send_byte(1'b1, 8'h47);
    chk("recover_sync", int'(sync_out), 1);
    chk("recover_locked", int'(locked), 1);
`ifdef TS_SYNC_ERRCNT_EN
    chk("err_after_two", int'(err_cnt), 2);
`endif
    send_payload(PKT_LEN - 1, 0, 1'b0);

    // Three misses drop lock.
    send_pkt(1'b0, 0, 1'b0);
    send_pkt(1'b0, 0, 1'b0);
    send_byte(1'b1, 8'h12);
    chk("loss_pulse", int'(lock_lost), 1);
    chk("loss_unlocked", int'(locked), 0);
    chk("loss_pos", int'(byte_pos), 0);
`ifdef TS_SYNC_ERRCNT_EN
    chk("err_after_loss", int'(err_cnt), 5);
`endif
    send_byte(1'b1, 8'h00);
    chk("loss_pulse_once", int'(lock_lost), 0);

    // Single candidate followed by a bad check byte returns to hunt.
    send_byte(1'b1, 8'h47);
    chk("cand_pos", int'(byte_pos), 1);
    send_payload(PKT_LEN - 1, 0, 1'b0);
    send_byte(1'b1, 8'h00);
    chk("verify_fail_pos", int'(byte_pos), 0);
    chk("verify_fail_unlocked", int'(locked), 0);

    // Relock with data_valid toggling every cycle.
    repeat (3) send_pkt(1'b1, 1, 1'b0);
    chk("toggle_locked", int'(locked), 1);
    send_byte(1'b1, 8'h47);
    chk("toggle_sync", int'(sync_out), 1);
    send_byte(1'b0, 8'h47);
    chk("toggle_idle_nosync", int'(sync_out), 0);
    chk("toggle_idle_pos", int'(byte_pos), 1);
    send_payload(PKT_LEN - 1, 1, 1'b0);

    // Asynchronous reset mid-packet while locked.
    send_byte(1'b1, 8'h47);
    send_payload(20, 0, 1'b0);
    data_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_locked", int'(locked), 0);
    chk("arst_pos", int'(byte_pos), 0);
    chk("arst_sync", int'(sync_out), 0);
    chk("arst_lost", int'(lock_lost), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    send_pkt(1'b1, 0, 1'b0);
    send_pkt(1'b1, 0, 1'b0);
    chk("relock_not_yet", int'(locked), 0);
    send_byte(1'b1, 8'h47);
    chk("relock_third", int'(locked), 1);
`ifdef TS_SYNC_ERRCNT_EN
    chk("err_cleared", int'(err_cnt), 0);
`endif
    send_payload(PKT_LEN - 1, 0, 1'b0);

    // Random traffic: phase slips, corrupted syncs, gaps, stray 0x47s.
    for (int k = 0; k < 70; k++) begin
      r   = int'($urandom_range(0, 99));
      gap = int'($urandom_range(0, 2));
      if (r < 10) send_payload(int'($urandom_range(1, 3)), gap, 1'b1);
      send_pkt(r >= 20, gap, 1'b1);
    end

    repeat (3) send_byte(1'b0, 8'h00);
    run_cmp = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ts_sync_detector.md
# ts_sync_detector

Per-channel MPEG-2 TS packet synchronizer: it takes one byte-wide TS stream, finds the 0x47 sync byte at the packet period, and runs a hunt/verify/lock state machine. It produces the per-channel `sync` strobe and lock status that feed the 4-to-1 sync selector in the QoS control path. Four instances, one per channel, drive `sync[3:0]` of the selector.

## Interface
Parameters:
- `PKT_LEN`, 188: packet length in bytes. Legal range 2..255.
- `SYNC_BYTE`, 8'h47: sync byte value.
- `LOCK_CNT`, 3: consecutive correct sync bytes, including the first one found, needed to declare lock. Legal range 1..7.
- `LOSS_CNT`, 3: consecutive missing sync bytes while locked that cause loss of lock. Legal range 1..7.

Ports:
- `clk` input 1: system clock. All logic is on the rising edge.
- `rst` input 1: asynchronous reset, active-high.
- `data_in` input 8: TS byte.
- `data_valid` input 1: `data_in` is accepted on a rising edge when this is high.
- `sync_out` output 1: one-cycle pulse, only while locked, marking an accepted sync byte.
- `locked` output 1: high in the LOCK state.
- `lock_lost` output 1: one-cycle pulse on the LOCK→HUNT transition.
- `byte_pos` output 8: position of the next expected byte within the packet, 0..PKT_LEN-1. Position 0 is the sync position.

## Operation
- Internal state: FSM {HUNT, VERIFY, LOCK}, `byte_pos`, `good` (3 bits), `miss` (3 bits).
- A byte is processed only in a cycle where `data_valid` is 1. When `data_valid` is 0, all state, counters and `byte_pos` hold, and pulse outputs are 0.
- `byte_pos` advance, VERIFY and LOCK only: `byte_pos` becomes 0 if it equals PKT_LEN-1, otherwise `byte_pos`+1. A byte is checked against SYNC_BYTE only when `byte_pos` = 0.
- **HUNT**
  - `data_in` = SYNC_BYTE: set `byte_pos`=1 and `good`=1.
    - If LOCK_CNT = 1, go to LOCK and pulse `sync_out`.
    - Otherwise go to VERIFY.
  - Other bytes: `byte_pos` stays 0.
- **VERIFY**
  - Check byte matches: `good`+1.
    - If the new value equals LOCK_CNT, go to LOCK, clear `miss`, and pulse `sync_out`.
  - Check byte mismatches: go to HUNT with `byte_pos`=0. The mismatching byte is not re-examined as a new sync candidate.
- **LOCK**
  - Check byte matches: `miss`=0 and pulse `sync_out`.
  - Check byte mismatches: `miss`+1. `byte_pos` keeps free-running.
    - If the new value equals LOSS_CNT, go to HUNT, set `byte_pos`=0, and pulse `lock_lost`.
  - No resynchronization to a different phase while locked.
- Non-check bytes never affect `good` or `miss`. 0x47 appearing in the payload is ignored outside HUNT.

## Timing
- All outputs are registered.
  - `sync_out` and `lock_lost` are high for exactly the one cycle after the edge that accepted the triggering byte.
  - `locked` rises in that same cycle and falls together with the `lock_lost` pulse.
- Latency from sync byte to `sync_out` is 1 cycle.
- Reset values: state HUNT, `byte_pos`=0, `good`=0, `miss`=0, `sync_out`=0, `locked`=0, `lock_lost`=0.
- Reset asserted mid-packet or while locked clears everything immediately, asynchronously. The first byte accepted after reset release is evaluated in HUNT.
- Back-to-back valid bytes: one byte per cycle, no stall.

## Configuration
- `TS_SYNC_ERRCNT_EN` defined: adds output `err_cnt` (16 bits).
  - Counts every sync mismatch seen in LOCK, including the one that causes loss of lock.
  - Saturates at 16'hFFFF.
  - Reset only by `rst`.
  - Registered, updating in the same cycle `miss` updates.
- Not defined: the port and its counter do not exist. All other behaviour is identical.

## Test plan
- Three packets of 188 bytes, each starting with 0x47, `data_valid`=1 continuously → `locked` rises 1 cycle after the third sync byte. The first `sync_out` pulse coincides with that rise, followed by one pulse per packet after it.
- In HUNT, 0x47 followed by a packet whose byte 188 is 0x00 → returns to HUNT with `byte_pos`=0. `locked` stays 0.
- While locked, corrupt 2 consecutive sync bytes and then send a good one → `locked` stays 1, `miss` returns to 0, and `sync_out` pulses on the good byte only. With `TS_SYNC_ERRCNT_EN` defined, `err_cnt`=2.
- While locked, corrupt 3 consecutive sync bytes → `lock_lost` pulses once and `locked` goes to 0, both 1 cycle after the third bad byte.
- Locked stream with `data_valid` toggling 1/0 every cycle → the same sync pulses appear, and `byte_pos` advances only on valid bytes.
- Assert `rst` for 1 cycle mid-packet while locked → all outputs are 0 asynchronously, and relock requires 3 new syncs.
